sram_axi_bridge: RTL
====================

Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core's two SRAM-style ports (instruction fetch, data access).
- Converts them into a single 32-bit AXI master with a reduced signal set: no IDs, no bursts, single beat only.
- Blocking design: exactly one transaction outstanding at a time.
- Arbitration is fixed priority, data over inst.

Parameters:
none (address and data are fixed at 32 bits; every AXI beat is a full word)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
inst_req  in  1  instruction read request
inst_addr  in  32  instruction byte address
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  instruction read data valid (1-cycle pulse)
inst_rdata  out  32  instruction read data
data_req  in  1  data request
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  4  write byte enables
data_addr  in  32  data byte address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data read returned / write acknowledged (1-cycle pulse)
data_rdata  out  32  data read data
araddr  out  32  AXI read address
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  32  AXI read data
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
awaddr  out  32  AXI write address
awvalid  out  1  AXI write address valid
awready  in  1  AXI write address ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobes
wvalid  out  1  AXI write data valid
wready  in  1  AXI write data ready
bvalid  in  1  AXI write response valid
bready  out  1  AXI write response ready

Behaviour:
- States: IDLE, AR, R, AW_W, B. Reset (async) puts the block in IDLE and clears owner, aw_done, w_done and all latched address/data registers.
- While reset is high, every valid, ready, addr_ok and data_ok output is 0.
- Arbitration, IDLE only:
  - data_addr_ok = data_req.
  - inst_addr_ok = inst_req & ~data_req.
  - Both *_addr_ok are 0 in every other state.
- Request acceptance (req & addr_ok):
  - Latch addr, wr, wstrb and wdata, plus owner (inst = 0, data = 1).
  - Next state is AW_W when the accepted request is a data write, otherwise AR.
  - An inst request is always a read.
- AR: arvalid = 1, araddr = latched address. Move to R on arready.
- R:
  - rready = 1.
  - On rvalid: the owner's *_data_ok = 1 in that same cycle (combinational) and *_rdata = rdata pass-through; next state IDLE.
  - The non-owner's data_ok stays 0.
- AW_W:
  - awvalid = ~aw_done; wvalid = ~w_done.
  - Each of aw_done / w_done is set on its own handshake; the two handshakes may complete in the same cycle or in either order.
  - When both are done (including completion in the current cycle), clear both flags and go to B.
- B: bready = 1. On bvalid, data_data_ok = 1 for one cycle, then IDLE.
- Hold rules:
  - awaddr, wdata, wstrb and araddr come from the latched registers and stay stable while their valid is high.
  - rready = 0 outside R and bready = 0 outside B, so stray rvalid/bvalid are never consumed.
- Inputs while busy: req inputs are ignored outside IDLE. The requester holds req and addr until it sees addr_ok, per the SRAM-style protocol.
- Minimum latency:
  - Read: accept at cycle 0, AR at cycle 1 (arready = 1), R at cycle 2, data_ok at cycle 2 if rvalid.
  - Write: accept at cycle 0, AW_W at cycle 1, B at cycle 2, data_ok at cycle 2 if bvalid.
  - Earliest next accept is the cycle after data_ok.
- Reset asserted mid-transaction: abandon immediately and return to IDLE. No pending data_ok is ever emitted afterwards.

Test Plan:
- Inst read, slave always ready: inst_addr = 0x1C000000, rdata = 0x02800C0C -> inst_addr_ok at cycle 0, arvalid with araddr = 0x1C000000 at cycle 1, inst_data_ok with inst_rdata = 0x02800C0C at cycle 2, no data_data_ok.
- Simultaneous inst_req and data read to 0x00000100 -> data_addr_ok = 1, inst_addr_ok = 0 -> data served first. inst is accepted the cycle after data_data_ok.
- Data write, addr 0x10, wdata 0xDEADBEEF, wstrb 4'b0011, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 0x10 until accepted, bready is asserted only after both handshakes, data_data_ok pulses exactly once on bvalid.
- Read with arready held low 5 cycles, then rvalid 4 cycles after the AR handshake -> araddr stable throughout, rready only in R, data_ok coincides with rvalid.
- Stray bvalid/rvalid while in IDLE -> no ready asserted, no data_ok.
- Reset asserted while in R -> all outputs 0 immediately, IDLE afterwards, no data_ok. A new inst request after reset completes normally.

Source files
------------

// File: rtl/sram_axi_bridge_if.sv
// rtl/sram_axi_bridge_if.sv - CPU SRAM-style port bundle and reduced single-beat AXI bundle

// CPU side: instruction fetch port plus data access port
interface bridge_sram_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
    );
    modport slave (
        input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// Memory side: no IDs, no bursts, one full-word beat per transaction
interface bridge_axi_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rvalid, awready, wready, bvalid
    );
    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - blocking two-port SRAM-style to single-beat AXI master bridge

module sram_axi_bridge (
    input  logic           clk,
    input  logic           reset,
    bridge_sram_if.slave   cpu,
    bridge_axi_if.master   axi
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4
    } state_t;

    state_t      state_q;
    logic        owner_q;      // 0 = inst port, 1 = data port
    logic        aw_done_q;
    logic        w_done_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;

    logic idle;
    logic aw_fire;
    logic w_fire;
    logic aw_now;
    logic w_now;

    assign idle    = (state_q == IDLE);
    assign aw_fire = awvalid_q & axi.awready;
    assign w_fire  = wvalid_q & axi.wready;
    assign aw_now  = aw_done_q | aw_fire;
    assign w_now   = w_done_q | w_fire;

    // Sequencer: arbitrates in IDLE, then walks one AXI transaction to completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu.data_req) begin
                        owner_q <= 1'b1;
                        addr_q  <= cpu.data_addr;
                        wdata_q <= cpu.data_wdata;
                        wstrb_q <= cpu.data_wstrb;
                        if (cpu.data_wr) begin
                            state_q   <= AW_W;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= AR;
                            arvalid_q <= 1'b1;
                        end
                    end else if (cpu.inst_req) begin
                        owner_q   <= 1'b0;
                        addr_q    <= cpu.inst_addr;
                        wstrb_q   <= 4'h0;
                        state_q   <= AR;
                        arvalid_q <= 1'b1;
                    end
                end
                AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                AW_W: begin
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    // Address and data may finish together or in either order
                    if (aw_now && w_now) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= B;
                    end
                end
                B: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Acceptance is gated by reset because the state is already IDLE while reset is held
    assign cpu.data_addr_ok = ~reset & idle & cpu.data_req;
    assign cpu.inst_addr_ok = ~reset & idle & cpu.inst_req & ~cpu.data_req;

    // Completion pulses follow the slave's rvalid/bvalid in the same cycle
    assign cpu.inst_data_ok = (state_q == R) & axi.rvalid & ~owner_q;
    assign cpu.data_data_ok = ((state_q == R) & axi.rvalid & owner_q) |
                              ((state_q == B) & axi.bvalid);
    assign cpu.inst_rdata   = axi.rdata;
    assign cpu.data_rdata   = axi.rdata;

    assign axi.araddr  = addr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = addr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule
